// File: rtl/ldst_pkg.sv
// ----------------------------------------------------------------------------
// ldst_pkg
//   Shared definitions for the banked-L1 load/store scheduler.
//   - ldst_state_t : scheduler FSM states (IDLE, ACCESS, DONE)
//   - LDST_*       : default geometry (SPs/banks, address, bank and row widths)
//   - bank_of()    : bank select = low BANK_WIDTH address bits
//   - row_of()     : per-bank row = remaining high address bits
// ----------------------------------------------------------------------------
package ldst_pkg;

  localparam int LDST_SP_PER_MP     = 8;
  localparam int LDST_L1_ADDR_WIDTH = 10;
  localparam int LDST_BANK_WIDTH    = $clog2(LDST_SP_PER_MP);
  localparam int LDST_ROW_WIDTH     = LDST_L1_ADDR_WIDTH - LDST_BANK_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } ldst_state_t;

  function automatic logic [LDST_BANK_WIDTH-1:0] bank_of(
    input logic [LDST_L1_ADDR_WIDTH-1:0] addr
  );
    return addr[LDST_BANK_WIDTH-1:0];
  endfunction

  function automatic logic [LDST_ROW_WIDTH-1:0] row_of(
    input logic [LDST_L1_ADDR_WIDTH-1:0] addr
  );
    return addr[LDST_L1_ADDR_WIDTH-1:LDST_BANK_WIDTH];
  endfunction

endpackage

// File: rtl/ldst_bank_pick.sv
// ----------------------------------------------------------------------------
// ldst_bank_pick
//   Row selection for one L1 bank. Among the SPs that are still pending and
//   target this bank, the lowest-index one decides the row; every such SP
//   asking for that same row is served in the same pass.
// Ports
//   match   in  [SP_PER_MP]            pending SPs that target this bank
//   rows    in  [SP_PER_MP][ROW_WIDTH] row requested by every SP
//   sel_row out [ROW_WIDTH]            selected row (0 when no SP matches)
//   en      out 1                      bank is accessed this pass
//   hit     out [SP_PER_MP]            SPs served by this bank this pass
// ----------------------------------------------------------------------------
module ldst_bank_pick #(
  parameter int SP_PER_MP = 8,
  parameter int ROW_WIDTH = 7
) (
  input  logic [SP_PER_MP-1:0]                match,
  input  logic [SP_PER_MP-1:0][ROW_WIDTH-1:0] rows,
  output logic [ROW_WIDTH-1:0]                sel_row,
  output logic                                en,
  output logic [SP_PER_MP-1:0]                hit
);

  // Scan from the top down so the lowest-index match is written last.
  always_comb begin
    sel_row = '0;
    for (int i = SP_PER_MP - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_row = rows[i];
      end
    end
  end

  assign en = |match;

  always_comb begin
    hit = '0;
    for (int i = 0; i < SP_PER_MP; i++) begin
      hit[i] = match[i] && (rows[i] == sel_row);
    end
  end

endmodule

// File: rtl/ldst_bank_sched.sv
// ----------------------------------------------------------------------------
// ldst_bank_sched
//   Sequences one warp load/store over the banked L1. The per-SP addresses,
//   store flag and thread mask are latched on accept; each pass then picks
//   one row per bank, grants every pending SP that hits that bank/row, and
//   replays the losers until the mask drains, then pulses done.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready warp op handshake (ready only while idle)
//   in_addrs          per-SP L1 word addresses
//   in_mask           active threads
//   in_we             1=store, 0=load for the whole warp
//   l1_ready          L1 takes the current pass; low stalls everything
//   bank_en/bank_row  per-bank enable and row for the current pass
//   bank_we           latched store flag, qualified by any bank enable
//   grant             SPs served by the current pass
//   done              one-cycle completion pulse
//   pass_cnt          passes used by the last op, held until next accept
//
// Build option
//   LDST_PERF_CNT_EN  adds perf_conflict_cnt[31:0], counting accepted passes
//                     that leave threads pending (replays); wraps at 2^32.
// ----------------------------------------------------------------------------
module ldst_bank_sched
  import ldst_pkg::*;
#(
  parameter  int SP_PER_MP     = LDST_SP_PER_MP,
  parameter  int L1_ADDR_WIDTH = LDST_L1_ADDR_WIDTH,
  localparam int BANK_WIDTH    = $clog2(SP_PER_MP),
  localparam int ROW_WIDTH     = L1_ADDR_WIDTH - BANK_WIDTH,
  localparam int PC_W          = $clog2(SP_PER_MP + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [SP_PER_MP-1:0][L1_ADDR_WIDTH-1:0] in_addrs,
  input  logic [SP_PER_MP-1:0]                    in_mask,
  input  logic                                    in_we,
  input  logic                                    l1_ready,
  output logic [SP_PER_MP-1:0]                    bank_en,
  output logic [SP_PER_MP-1:0][ROW_WIDTH-1:0]     bank_row,
  output logic                                    bank_we,
  output logic [SP_PER_MP-1:0]                    grant,
  output logic                                    done,
  output logic [PC_W-1:0]                         pass_cnt
`ifdef LDST_PERF_CNT_EN
  ,output logic [31:0]                            perf_conflict_cnt
`endif
);

  ldst_state_t                             state_q, state_d;
  logic [SP_PER_MP-1:0]                    pending_q, pending_d;
  logic [PC_W-1:0]                         pass_cnt_q, pass_cnt_d;
  logic [SP_PER_MP-1:0][L1_ADDR_WIDTH-1:0] addrs_q, addrs_d;
  logic                                    we_q, we_d;
`ifdef LDST_PERF_CNT_EN
  logic [31:0]                             perf_q, perf_d;
`endif

  logic [SP_PER_MP-1:0][BANK_WIDTH-1:0]    sp_bank;
  logic [SP_PER_MP-1:0][ROW_WIDTH-1:0]     sp_row;
  logic [SP_PER_MP-1:0][SP_PER_MP-1:0]     bank_match;
  logic [SP_PER_MP-1:0][SP_PER_MP-1:0]     bank_hit;
  logic [SP_PER_MP-1:0][ROW_WIDTH-1:0]     sel_row;
  logic [SP_PER_MP-1:0]                    sel_en;
  logic [SP_PER_MP-1:0]                    hit_any;
  logic                                    access;

  // Address split of the latched warp.
  always_comb begin
    for (int i = 0; i < SP_PER_MP; i++) begin
      sp_bank[i] = bank_of(addrs_q[i]);
      sp_row[i]  = row_of(addrs_q[i]);
    end
  end

  // bank_match[b][i]: SP i is still pending and targets bank b.
  always_comb begin
    for (int b = 0; b < SP_PER_MP; b++) begin
      for (int i = 0; i < SP_PER_MP; i++) begin
        bank_match[b][i] = pending_q[i] && (sp_bank[i] == BANK_WIDTH'(b));
      end
    end
  end

  for (genvar b = 0; b < SP_PER_MP; b++) begin : g_bank
    ldst_bank_pick #(
      .SP_PER_MP (SP_PER_MP),
      .ROW_WIDTH (ROW_WIDTH)
    ) u_pick (
      .match   (bank_match[b]),
      .rows    (sp_row),
      .sel_row (sel_row[b]),
      .en      (sel_en[b]),
      .hit     (bank_hit[b])
    );
  end

  // An SP targets exactly one bank, so OR-ing the per-bank hits is the grant.
  always_comb begin
    hit_any = '0;
    for (int b = 0; b < SP_PER_MP; b++) begin
      hit_any = hit_any | bank_hit[b];
    end
  end

  assign access   = (state_q == ACCESS);
  assign bank_en  = access ? sel_en  : '0;
  assign bank_row = access ? sel_row : '0;
  assign grant    = access ? hit_any : '0;
  assign bank_we  = we_q & (|bank_en);
  assign done     = (state_q == DONE);
  assign in_ready = (state_q == IDLE);
  assign pass_cnt = pass_cnt_q;
`ifdef LDST_PERF_CNT_EN
  assign perf_conflict_cnt = perf_q;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pass_cnt_d = pass_cnt_q;
    addrs_d    = addrs_q;
    we_d       = we_q;
`ifdef LDST_PERF_CNT_EN
    perf_d     = perf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addrs_d    = in_addrs;
          we_d       = in_we;
          pending_d  = in_mask;
          pass_cnt_d = '0;
          state_d    = (in_mask != '0) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        // Every pass grants at least one SP, so pass_cnt cannot overflow.
        if (l1_ready) begin
          pending_d  = pending_q & ~hit_any;
          pass_cnt_d = pass_cnt_q + PC_W'(1);
          if (pending_d == '0) begin
            state_d = DONE;
          end
`ifdef LDST_PERF_CNT_EN
          else begin
            perf_d = perf_q + 32'd1;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      pass_cnt_q <= '0;
`ifdef LDST_PERF_CNT_EN
      perf_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pass_cnt_q <= pass_cnt_d;
`ifdef LDST_PERF_CNT_EN
      perf_q     <= perf_d;
`endif
    end
  end

  // Latched warp payload: only meaningful while pending is non-zero.
  always_ff @(posedge clk) begin
    addrs_q <= addrs_d;
    we_q    <= we_d;
  end

endmodule

// File: tb/tb_ldst_bank_sched.sv
// ----------------------------------------------------------------------------
// tb_ldst_bank_sched
//   Self-checking bench for ldst_bank_sched: directed warp ops followed by
//   random ones, compared pass by pass against a bank/row reference model.
// ----------------------------------------------------------------------------
module tb_ldst_bank_sched;

  localparam int N  = 8;
  localparam int AW = 10;
  localparam int RW = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0][AW-1:0] in_addrs;
  logic [N-1:0]         in_mask;
  logic                 in_we;
  logic                 l1_ready;
  logic [N-1:0]         bank_en;
  logic [N-1:0][RW-1:0] bank_row;
  logic                 bank_we;
  logic [N-1:0]         grant;
  logic                 done;
  logic [3:0]           pass_cnt;
`ifdef LDST_PERF_CNT_EN
  logic [31:0]          perf_conflict_cnt;
`endif

  ldst_bank_sched dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addrs (in_addrs),
    .in_mask  (in_mask),
    .in_we    (in_we),
    .l1_ready (l1_ready),
    .bank_en  (bank_en),
    .bank_row (bank_row),
    .bank_we  (bank_we),
    .grant    (grant),
    .done     (done),
    .pass_cnt (pass_cnt)
`ifdef LDST_PERF_CNT_EN
    ,.perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  longint perf_exp = 0;

  int          op_addr [N];
  logic [N-1:0] op_mask;
  logic         op_we;

  logic [N-1:0]  exp_grant [$];
  logic [N-1:0]  exp_en    [$];
  logic [63:0]   exp_row   [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: bank = addr mod N, row = addr div N. Per pass, each bank serves
  // the address of its lowest-index pending SP, and every pending SP asking
  // for that exact address is served with it.
  task automatic build_model();
    logic [N-1:0] pend, g, en;
    logic [63:0]  rows;
    exp_grant.delete(); exp_en.delete(); exp_row.delete();
    pend = op_mask;
    while (pend != '0) begin
      g = '0; en = '0; rows = '0;
      for (int b = 0; b < N; b++) begin
        int first;
        first = -1;
        for (int i = 0; i < N; i++)
          if (first < 0 && pend[i] && (op_addr[i] % N) == b) first = i;
        if (first >= 0) begin
          en[b] = 1'b1;
          rows[b*RW +: RW] = RW'(op_addr[first] / N);
          for (int i = 0; i < N; i++)
            if (pend[i] && op_addr[i] == op_addr[first]) g[i] = 1'b1;
        end
      end
      exp_grant.push_back(g); exp_en.push_back(en); exp_row.push_back(rows);
      pend = pend & ~g;
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef LDST_PERF_CNT_EN
    check(tag, perf_conflict_cnt, perf_exp[31:0]);
`endif
  endtask

  // One warp op. stall_pass/stall_len force l1_ready low in one pass;
  // rnd_stall adds random stalls; abort_pass asserts rst in that pass.
  task automatic run_op(input string nm, input int stall_pass, input int stall_len,
                        input bit rnd_stall, input int abort_pass);
    int np;
    build_model();
    np = exp_grant.size();
    @(negedge clk);
    check({nm, ":in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_mask = op_mask; in_we = op_we; l1_ready = 1'b0;
    for (int i = 0; i < N; i++) in_addrs[i] = AW'(op_addr[i]);
    @(negedge clk);
    // Scramble inputs so anything not latched would show up.
    in_valid = 1'b0; in_mask = N'($urandom); in_we = ~op_we;
    for (int i = 0; i < N; i++) in_addrs[i] = AW'($urandom);
    for (int p = 0; p < np; p++) begin
      int stalls;
      stalls = (p == stall_pass) ? stall_len : 0;
      if (rnd_stall) stalls += $urandom_range(0, 2);
      for (int s = 0; s <= stalls; s++) begin
        check({nm, ":grant"},    grant,    exp_grant[p]);
        check({nm, ":bank_en"},  bank_en,  exp_en[p]);
        check({nm, ":bank_row"}, bank_row, exp_row[p]);
        check({nm, ":bank_we"},  bank_we,  op_we);
        check({nm, ":busy"},     {in_ready, done}, 2'b00);
        if (p == abort_pass) begin
          rst = 1'b1;
          #1;
          check({nm, ":rst_ready"}, in_ready, 1);
          check({nm, ":rst_outs"},  {bank_en, grant, bank_we, done}, '0);
          check({nm, ":rst_pass_cnt"}, pass_cnt, 0);
          perf_exp = 0;
          check_perf({nm, ":rst_perf"});
          @(negedge clk);
          rst = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({nm, ":no_done_after_rst"}, {done, in_ready}, 2'b01);
          end
          return;
        end
        l1_ready = (s == stalls) ? 1'b1 : 1'b0;
        @(negedge clk);
      end
    end
    l1_ready = 1'b0;
    check({nm, ":done"},      done, 1);
    check({nm, ":done_outs"}, {bank_en, grant, bank_we, in_ready}, '0);
    check({nm, ":pass_cnt"},  pass_cnt, np);
    perf_exp += (np > 0) ? np - 1 : 0;
    check_perf({nm, ":perf"});
    @(negedge clk);
    check({nm, ":done_pulse"}, {done, in_ready}, 2'b01);
    check({nm, ":pass_cnt_hold"}, pass_cnt, np);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addrs = '0; in_mask = '0; in_we = 1'b0; l1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset:in_ready", in_ready, 1);
    check("reset:outs", {bank_en, grant, bank_we, done}, '0);
    check("reset:pass_cnt", pass_cnt, 0);
    check_perf("reset:perf");
    rst = 1'b0;

    // 1: all banks distinct
    op_mask = 8'hFF; op_we = 1'b0;
    for (int i = 0; i < N; i++) op_addr[i] = i;
    run_op("t1", -1, 0, 1'b0, -1);

    // 2: all bank 0, rows 0..7
    op_mask = 8'hFF; op_we = 1'b1;
    for (int i = 0; i < N; i++) op_addr[i] = i * 8;
    run_op("t2", -1, 0, 1'b0, -1);

    // 3: merge of SP0/SP2 at 40, SP4 at 56
    op_mask = 8'h15; op_we = 1'b0;
    for (int i = 0; i < N; i++) op_addr[i] = $urandom_range(0, 1023);
    op_addr[0] = 40; op_addr[2] = 40; op_addr[4] = 56;
    run_op("t3", -1, 0, 1'b0, -1);

    // 4: case 2 with 3 stall cycles in pass 3
    op_mask = 8'hFF; op_we = 1'b1;
    for (int i = 0; i < N; i++) op_addr[i] = i * 8;
    run_op("t4", 2, 3, 1'b0, -1);

    // 5: empty mask
    op_mask = 8'h00; op_we = 1'b1;
    run_op("t5", -1, 0, 1'b0, -1);

    // 6: reset in pass 4 of case 2, then a normal op
    op_mask = 8'hFF; op_we = 1'b0;
    for (int i = 0; i < N; i++) op_addr[i] = i * 8;
    run_op("t6", -1, 0, 1'b0, 3);
    for (int i = 0; i < N; i++) op_addr[i] = i;
    run_op("t6b", -1, 0, 1'b0, -1);

    // Random ops, biased toward bank conflicts and merges
    for (int t = 0; t < 60; t++) begin
      op_mask = N'($urandom);
      op_we   = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) op_addr[i] = $urandom_range(0, 1023);
        else op_addr[i] = $urandom_range(0, 3) * 8 + $urandom_range(0, 3);
      end
      run_op("rnd", -1, 0, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
